ir_rx_arbiter: RTL and testbench
================================

IR_RX_ARBITER -- requirements
Module: ir_rx_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning the number of demodulated IR inputs sharing one output.
REQ-002 SHALL have parameter IDLE_CYC, default 250000, meaning the inter-frame high time (10 ms at 25 MHz) that releases a grant.
REQ-003 SHALL have parameter MAX_CYC, default 3000000, meaning the frame watchdog limit (120 ms at 25 MHz).
REQ-004 SHALL have port clk, input, 1 bit: 25 MHz clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port ir_i, input, N_CH bits: demodulated IR lines, idle high, active low, asynchronous to clk.
REQ-007 SHALL have port ch_en, input, N_CH bits: per-channel enable; a 0 bit excludes that channel.
REQ-008 SHALL have port ir_o, output, 1 bit: the arbitrated IR line, idle high.
REQ-009 SHALL have port gnt, output, N_CH bits: one-hot grant, all zero when no channel is granted.
REQ-010 SHALL have port busy, output, 1 bit: high when the state is GRANT or FLUSH.
REQ-011 SHALL have port wdog_err, output, 1 bit: one-cycle pulse when a frame exceeds MAX_CYC.

Function
REQ-012 SHALL pass each ir_i bit through a two-flop synchronizer that resets to 1; the second flop's value is "s[i]".
REQ-013 SHALL implement the states IDLE, GRANT and FLUSH.
REQ-014 IDLE: if any enabled s[i] is 0, SHALL go to GRANT on the next edge, granting the first such i searched from rr_ptr upward, modulo N_CH.
REQ-015 SHALL register ir_o: in GRANT, ir_o <= s[granted]; in IDLE and FLUSH, ir_o <= 1. This gives 3 clk edges of latency from ir_i to ir_o.
REQ-016 In GRANT, SHALL ignore all non-granted channels, including their low levels.
REQ-017 In GRANT, the idle counter SHALL clear whenever s[granted]=0 and increment whenever s[granted]=1.
- When it reaches IDLE_CYC, SHALL go to IDLE, clear gnt, and set rr_ptr to granted+1 mod N_CH.
REQ-018 In GRANT, the frame counter SHALL count every cycle.
- When it reaches MAX_CYC, SHALL go to FLUSH, pulse wdog_err for one cycle, clear gnt, and force ir_o to 1.
REQ-019 In FLUSH, SHALL leave only after s[last granted] has been 1 for IDLE_CYC consecutive cycles, then go to IDLE and advance rr_ptr as in REQ-017.
REQ-020 If ch_en[granted] drops in GRANT or FLUSH, SHALL go to IDLE on the next edge with ir_o=1 and gnt=0, and rr_ptr advanced.
REQ-021 If the idle and frame limits are reached in the same cycle, the idle release (REQ-017) SHALL win and wdog_err SHALL NOT pulse.
REQ-022 Counters SHALL saturate, never wrap; widths SHALL be $clog2(limit+1).
REQ-023 The IDLE to GRANT decision SHALL use the current-cycle s[] and ch_en only.

Reset
REQ-024 On rst_n low, SHALL set state=IDLE, ir_o=1, gnt=0, busy=0, wdog_err=0, rr_ptr=0, both counters 0, and all synchronizer flops 1.
REQ-025 Reset mid-frame SHALL abort the frame immediately (asynchronously), with no glitch low on ir_o.

Structure
REQ-026 Package ir_pkg SHALL hold the state enum, default N_CH, and the 25 MHz-derived IDLE_CYC/MAX_CYC constants.
REQ-027 The two-flop synchronizer SHALL be the sub-module ir_sync2, instantiated per channel.

Verification (N_CH=4, IDLE_CYC=16, MAX_CYC=200)
REQ-028 With ch 2 low for 10 cycles, then high: gnt=0100 and ir_o low 3 edges after the fall; after 16 high cycles gnt=0000; rr_ptr=3.
REQ-029 With ch 0 and ch 1 falling in the same cycle and rr_ptr=1: gnt=0010; ch 0 activity stays masked until release.
REQ-030 With ch 3 held low for 250 cycles: wdog_err pulses once at frame cycle 200, ir_o=1, state FLUSH; IDLE returns 16 cycles after ch 3 goes high.
REQ-031 With ch_en[1] cleared during a ch 1 grant: the next edge gives gnt=0000 and ir_o=1; a low on ch 1 while disabled gives no grant.
REQ-032 With rst_n pulsed low mid-frame: ir_o=1 and gnt=0 immediately; after release, a still-low channel is re-granted after 3 edges.
REQ-033 With ch 1 showing 15 high cycles, then low, then 16 high: the grant persists through the 15-cycle gap and releases only after the 16th.

Source files
------------

// File: rtl/ir_pkg.sv
// ir_pkg: shared state encoding and 25 MHz timing defaults for the IR receive arbiter
package ir_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_FLUSH = 2'd2} state_t;
  localparam int N_CH_DEF     = 4;
  localparam int CLK_HZ       = 25_000_000;
  localparam int IDLE_CYC_DEF = CLK_HZ / 100;
  localparam int MAX_CYC_DEF  = CLK_HZ / 1000 * 120;
endpackage

// File: rtl/ir_sync2.sv
// ir_sync2: two-flop synchronizer for one idle-high IR line, resets to idle
module ir_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  // Resetting to 1 keeps a reset from looking like a falling IR edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= 1'b1;
      q <= 1'b1;
    end else begin
      m <= d;
      q <= m;
    end
  end
endmodule

// File: rtl/ir_rx_arbiter.sv
// ir_rx_arbiter: round-robin arbiter sharing one IR output among N_CH demodulated receivers
module ir_rx_arbiter
  import ir_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int IDLE_CYC = IDLE_CYC_DEF,
  parameter int MAX_CYC  = MAX_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] ir_i,
  input  logic [N_CH-1:0] ch_en,
  output logic            ir_o,
  output logic [N_CH-1:0] gnt,
  output logic            busy,
  output logic            wdog_err
);
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam int FW = $clog2(MAX_CYC + 1);
  logic [N_CH-1:0] s, gnt_n;
  state_t state, state_n;
  logic [PW-1:0] rr, rr_n, cur, cur_n, sel, nxt_ptr;
  logic [IW-1:0] idle_cnt, idle_n, idle_inc;
  logic [FW-1:0] frm_cnt, frm_n, frm_inc;
  logic found, ir_n, wdog_n;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    ir_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(ir_i[g]), .q(s[g]));
  end

  // Round-robin search from rr upward; iterating backwards lets the nearest hit win
  always_comb begin
    logic [PW-1:0] j;
    found = 1'b0;
    sel = rr;
    j = rr;
    for (int k = N_CH - 1; k >= 0; k--) begin
      j = PW'((int'(rr) + k) % N_CH);
      if (ch_en[j] && !s[j]) begin
        found = 1'b1;
        sel = j;
      end
    end
  end

  // Saturating counter increments and the post-release pointer
  always_comb begin
    idle_inc = s[cur] ? ((idle_cnt == IW'(IDLE_CYC)) ? idle_cnt : idle_cnt + 1'b1) : '0;
    frm_inc  = (frm_cnt == FW'(MAX_CYC)) ? frm_cnt : frm_cnt + 1'b1;
    nxt_ptr  = (cur == PW'(N_CH - 1)) ? '0 : cur + 1'b1;
  end

  // Next-state logic; enable loss beats idle release, which beats the watchdog
  always_comb begin
    state_n = state;
    rr_n    = rr;
    cur_n   = cur;
    idle_n  = '0;
    frm_n   = '0;
    ir_n    = 1'b1;
    wdog_n  = 1'b0;
    gnt_n   = '0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_n = ST_GRANT;
          cur_n   = sel;
          ir_n    = s[sel];
          gnt_n   = N_CH'(1) << sel;
        end
      end
      ST_GRANT: begin
        if (!ch_en[cur] || idle_inc == IW'(IDLE_CYC)) begin
          state_n = ST_IDLE;
          rr_n    = nxt_ptr;
        end else if (frm_inc == FW'(MAX_CYC)) begin
          state_n = ST_FLUSH;
          wdog_n  = 1'b1;
        end else begin
          idle_n = idle_inc;
          frm_n  = frm_inc;
          ir_n   = s[cur];
          gnt_n  = N_CH'(1) << cur;
        end
      end
      default: begin
        if (!ch_en[cur] || idle_inc == IW'(IDLE_CYC)) begin
          state_n = ST_IDLE;
          rr_n    = nxt_ptr;
        end else begin
          idle_n = idle_inc;
        end
      end
    endcase
  end

  // State and registered outputs; reset forces the line idle without a glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr       <= '0;
      cur      <= '0;
      idle_cnt <= '0;
      frm_cnt  <= '0;
      ir_o     <= 1'b1;
      gnt      <= '0;
      wdog_err <= 1'b0;
    end else begin
      state    <= state_n;
      rr       <= rr_n;
      cur      <= cur_n;
      idle_cnt <= idle_n;
      frm_cnt  <= frm_n;
      ir_o     <= ir_n;
      gnt      <= gnt_n;
      wdog_err <= wdog_n;
    end
  end

  assign busy = (state != ST_IDLE);
endmodule

// File: tb/tb_ir_rx_arbiter.sv
// tb_ir_rx_arbiter: directed and random checks of ir_rx_arbiter against a behavioural model
module tb_ir_rx_arbiter;
  localparam int N = 4;
  localparam int IDLE = 16;
  localparam int MAXC = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] ir_i = '1;
  logic [N-1:0] ch_en = '1;
  logic ir_o, busy, wdog_err;
  logic [N-1:0] gnt;
  int total = 0;
  int bad = 0;
  int wd_cnt = 0;

  ir_rx_arbiter #(.N_CH(N), .IDLE_CYC(IDLE), .MAX_CYC(MAX_CYC_T())) dut (
    .clk(clk), .rst_n(rst_n), .ir_i(ir_i), .ch_en(ch_en),
    .ir_o(ir_o), .gnt(gnt), .busy(busy), .wdog_err(wdog_err)
  );

  function automatic int MAX_CYC_T();
    return MAXC;
  endfunction

  always #20 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: ints for the granted channel (-1 = none), run lengths and pointer
  logic [N-1:0] s1, s2;
  int m_g, m_rr, m_hi, m_fr;
  bit m_fl;
  logic e_ir, e_wd;
  logic [N-1:0] e_gnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 = '1; s2 = '1; m_g = -1; m_rr = 0; m_hi = 0; m_fr = 0; m_fl = 0;
      e_ir = 1'b1; e_wd = 1'b0; e_gnt = '0;
    end else begin
      e_wd = 1'b0;
      e_ir = 1'b1;
      if (m_g < 0) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_rr + k) % N;
          if (m_g < 0 && ch_en[i] && !s2[i]) begin
            m_g = i; m_hi = 0; m_fr = 0; m_fl = 0; e_ir = 1'b0;
          end
        end
      end else begin
        int run;
        run = s2[m_g] ? m_hi + 1 : 0;
        if (!ch_en[m_g] || run >= IDLE) begin
          m_rr = (m_g + 1) % N; m_g = -1; m_fl = 0;
        end else if (m_fl) begin
          m_hi = run;
        end else if (m_fr + 1 >= MAXC) begin
          m_fl = 1; e_wd = 1'b1; m_hi = 0;
        end else begin
          m_fr++; m_hi = run; e_ir = s2[m_g];
        end
      end
      e_gnt = (m_g >= 0 && !m_fl) ? N'(1) << m_g : '0;
      s2 = s1;
      s1 = ir_i;
    end
  end

  // Cycle-by-cycle compare against the model once reset is released
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("ir_o", int'(ir_o), int'(e_ir));
      chk("gnt", int'(gnt), int'(e_gnt));
      chk("busy", int'(busy), int'(m_g >= 0));
      chk("wdog_err", int'(wdog_err), int'(e_wd));
      if (wdog_err) wd_cnt++;
    end
  end

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poss(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int hold[N];
    int wd0;
    negs(3);
    chk("rst_ir_o", int'(ir_o), 1);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wdog", int'(wdog_err), 0);
    rst_n = 1'b1;
    negs(3);
    // ch 2 frame: grant and low output three edges after the fall, release after 16 highs
    ir_i[2] = 1'b0;
    poss(3);
    chk("c2_gnt", int'(gnt), 4'b0100);
    chk("c2_ir_o", int'(ir_o), 0);
    negs(8);
    ir_i[2] = 1'b1;
    poss(17);
    chk("c2_hold", int'(gnt), 4'b0100);
    poss(1);
    chk("c2_rel", int'(gnt), 0);
    // rr now 3: ch 3 beats ch 0
    @(negedge clk);
    ir_i[0] = 1'b0; ir_i[3] = 1'b0;
    poss(3);
    chk("rr3_gnt", int'(gnt), 4'b1000);
    @(negedge clk);
    ir_i = '1;
    negs(22);
    // grant ch 0 to move rr to 1
    ir_i[0] = 1'b0;
    negs(3);
    ir_i[0] = 1'b1;
    negs(22);
    ir_i[0] = 1'b0; ir_i[1] = 1'b0;
    poss(3);
    chk("tie_gnt", int'(gnt), 4'b0010);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      ir_i[0] = ~ir_i[0];
    end
    poss(1);
    chk("mask_gnt", int'(gnt), 4'b0010);
    @(negedge clk);
    ir_i = '1;
    negs(22);
    // watchdog on ch 3 held low for 250 cycles
    wd0 = wd_cnt;
    ir_i[3] = 1'b0;
    poss(202);
    chk("wd_early", int'(wdog_err), 0);
    poss(1);
    chk("wd_pulse", int'(wdog_err), 1);
    chk("wd_gnt", int'(gnt), 0);
    chk("wd_busy", int'(busy), 1);
    chk("wd_ir_o", int'(ir_o), 1);
    negs(48);
    ir_i[3] = 1'b1;
    poss(17);
    chk("fl_busy", int'(busy), 1);
    poss(1);
    chk("fl_idle", int'(busy), 0);
    chk("wd_once", wd_cnt - wd0, 1);
    negs(5);
    // enable loss during ch 1 grant
    ir_i[1] = 1'b0;
    poss(3);
    chk("en_gnt", int'(gnt), 4'b0010);
    @(negedge clk);
    ch_en[1] = 1'b0;
    poss(1);
    chk("en_drop_gnt", int'(gnt), 0);
    chk("en_drop_ir", int'(ir_o), 1);
    negs(10);
    chk("en_off_gnt", int'(gnt), 0);
    ir_i[1] = 1'b1;
    ch_en = '1;
    negs(5);
    // asynchronous reset mid-frame, then re-grant of a still-low channel
    ir_i[2] = 1'b0;
    poss(8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ir_o", int'(ir_o), 1);
    chk("arst_gnt", int'(gnt), 0);
    chk("arst_busy", int'(busy), 0);
    negs(2);
    rst_n = 1'b1;
    poss(2);
    chk("rg_early", int'(gnt), 0);
    poss(1);
    chk("rg_gnt", int'(gnt), 4'b0100);
    @(negedge clk);
    ir_i[2] = 1'b1;
    negs(22);
    // 15-cycle gap keeps the grant, 16 high cycles release it
    ir_i[1] = 1'b0;
    negs(3);
    ir_i[1] = 1'b1;
    negs(15);
    ir_i[1] = 1'b0;
    negs(1);
    ir_i[1] = 1'b1;
    poss(17);
    chk("gap_hold", int'(gnt), 4'b0010);
    poss(1);
    chk("gap_rel", int'(gnt), 0);
    // random traffic
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          ir_i[i] = ~ir_i[i];
          hold[i] = ir_i[i] ? $urandom_range(1, 25)
                            : (($urandom_range(0, 15) == 0) ? $urandom_range(190, 240) : $urandom_range(1, 30));
        end else hold[i]--;
      end
      if ($urandom_range(0, 299) == 0) ch_en[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 1999) == 0) begin
        rst_n = 1'b0;
        negs(1);
        rst_n = 1'b1;
      end
    end
    negs(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
